aidc_comp_sel_ctrl: RTL

- Per-burst scheduler for the AIDC write-compression datapath.
- Waits for every compressor engine (ZRL, SR, BPC) to report a compressed size, then picks the smallest, or the raw path if no engine helps.
- Streams the chosen engine's FIFO to the memory W channel and discards the packet from every other FIFO.
- Drives the data-selector index and the compFlag that accompanies the burst.

---
 rtl/aidc_comp_sel_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/aidc_comp_sel_ctrl.sv
// Per-burst compression source scheduler: collects engine size reports, picks the
// smallest useful compressed packet (or raw), streams it to memory and drops the rest.
module aidc_comp_sel_ctrl #(
  parameter int NUM_ENG   = 3,
  parameter int BURST_LEN = 4,
  parameter int SIZE_W    = 3,
  parameter int SEL_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_ENG-1:0]        size_valid_i,
  input  logic [NUM_ENG*SIZE_W-1:0] size_i,
  output logic                      size_ready_o,
  input  logic [NUM_ENG:0]          fifo_valid_i,
  output logic [NUM_ENG:0]          fifo_pop_o,
  output logic                      mem_wvalid_o,
  input  logic                      mem_wready_i,
  output logic                      mem_wlast_o,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      comp_flag_o,
  output logic                      pkt_done_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECIDE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]        state;
  logic [SIZE_W-1:0] size_q [NUM_ENG];
  logic [SIZE_W-1:0] cnt    [NUM_ENG+1];
  logic [SEL_W-1:0]  sel_q;
  logic              comp_q;
  logic [SEL_W-1:0]  best_sel;
  logic [SIZE_W-1:0] best_size;
  logic              all_zero;

  // Strict '<' keeps the lowest index on ties; starting at BURST_LEN excludes sizes >= BURST_LEN.
  always_comb begin
    best_sel  = SEL_W'(NUM_ENG);
    best_size = SIZE_W'(BURST_LEN);
    for (int k = 0; k < NUM_ENG; k++) begin
      if (size_q[k] != '0 && size_q[k] < best_size) begin
        best_sel  = SEL_W'(k);
        best_size = size_q[k];
      end
    end
  end

  // Selected source obeys mem backpressure; every other source discards freely.
  always_comb begin
    fifo_pop_o   = '0;
    mem_wvalid_o = 1'b0;
    mem_wlast_o  = 1'b0;
    all_zero     = 1'b1;
    for (int i = 0; i < NUM_ENG + 1; i++) begin
      if (cnt[i] != '0) all_zero = 1'b0;
      if (state == DRAIN && fifo_valid_i[i] && cnt[i] != '0) begin
        if (SEL_W'(i) == sel_q) begin
          mem_wvalid_o  = 1'b1;
          mem_wlast_o   = (cnt[i] == SIZE_W'(1));
          fifo_pop_o[i] = mem_wready_i;
        end else begin
          fifo_pop_o[i] = 1'b1;
        end
      end
    end
  end

  assign size_ready_o = (state == IDLE) && (&size_valid_i);
  assign pkt_done_o   = (state == DRAIN) && all_zero;
  assign sel_o        = sel_q;
  assign comp_flag_o  = comp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel_q  <= '0;
      comp_q <= 1'b0;
      for (int k = 0; k < NUM_ENG; k++) size_q[k] <= '0;
      for (int i = 0; i < NUM_ENG + 1; i++) cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (&size_valid_i) begin
            for (int k = 0; k < NUM_ENG; k++) size_q[k] <= size_i[k*SIZE_W +: SIZE_W];
            state <= DECIDE;
          end
        end
        DECIDE: begin
          sel_q  <= best_sel;
          comp_q <= (best_sel != SEL_W'(NUM_ENG));
          for (int k = 0; k < NUM_ENG; k++) cnt[k] <= size_q[k];
          cnt[NUM_ENG] <= SIZE_W'(BURST_LEN);
          state        <= DRAIN;
        end
        DRAIN: begin
          for (int i = 0; i < NUM_ENG + 1; i++) begin
            if (fifo_pop_o[i]) cnt[i] <= cnt[i] - SIZE_W'(1);
          end
          // The done pulse doubles as the DONE step: one cycle, then back to IDLE.
          if (all_zero) begin
            comp_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
